// File: rtl/dpram_key_ctrl_pkg.sv
// Shared types and constants for the dual-port RAM key sequencer.
package dpram_key_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_WRITE = 4'b0010,
        ST_READ  = 4'b0100,
        ST_CLEAR = 4'b1000
    } state_e;

    localparam logic [7:0] DEF_PATTERN = 8'hA5;
    localparam int         LP_CNT_W    = 26;

endpackage

// File: rtl/long_press_det.sv
// Key hold counter; emits a single-cycle hit when the hold reaches LONG_CNT cycles.
module long_press_det #(
    parameter int             CNT_W    = 26,
    parameter logic [CNT_W-1:0] LONG_CNT = CNT_W'(49_999_999)
) (
    input  logic clk,
    input  logic rst,
    input  logic key_state,
    output logic hit
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating at LONG_CNT keeps the equality below true for one cycle only.
    always_comb begin
        cnt_d = '0;
        if (key_state) cnt_d = (cnt_q == LONG_CNT) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign hit = key_state && (cnt_q == LONG_CNT - CNT_W'(1));

endmodule

// File: rtl/dpram_key_ctrl.sv
// Key-driven write/read/clear sequencer for the dual-port RAM test design.
// Define DPRAM_KEY_CTRL_CHECK_EN to enable the read-data checker and err_cnt.
module dpram_key_ctrl
    import dpram_key_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                BURST_LEN = 4,
    parameter logic [DATA_W-1:0] PATTERN   = DATA_W'(DEF_PATTERN),
    parameter logic [LP_CNT_W-1:0] LONG_CNT = 26'd49_999_999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key0_flag,
    input  logic              key0_state,
    input  logic              key1_flag,
    input  logic              key1_state,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wren,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rden,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int BEAT_W = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    function automatic logic [DATA_W-1:0] pat_of(input logic [ADDR_W-1:0] a);
        logic [ADDR_W+7:0] ext;
        ext = {8'd0, a};
        return ext[DATA_W-1:0] ^ PATTERN;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              pend_w_q, pend_w_d, pend_r_q, pend_r_d, pend_c_q, pend_c_d;
    logic              rd_valid_q;
    logic              lp_hit;

    long_press_det #(.CNT_W(LP_CNT_W), .LONG_CNT(LONG_CNT)) u_lp (
        .clk      (clk),
        .rst      (rst),
        .key_state(key1_state),
        .hit      (lp_hit)
    );

    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        beat_d   = beat_q;
        pend_w_d = pend_w_q | key0_flag;
        pend_r_d = pend_r_q | key1_flag;
        pend_c_d = pend_c_q | lp_hit;
        unique case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                if (pend_c_q) begin
                    state_d  = ST_CLEAR;
                    pend_c_d = 1'b0;
                end else if (pend_w_q) begin
                    state_d  = ST_WRITE;
                    pend_w_d = 1'b0;
                end else if (pend_r_q) begin
                    state_d  = ST_READ;
                    pend_r_d = 1'b0;
                end
            end
            ST_WRITE: begin
                wp_d   = wp_q + ADDR_W'(1);
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) state_d = ST_IDLE;
            end
            ST_READ: begin
                rp_d   = rp_q + ADDR_W'(1);
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                // Drop queued bursts but keep a flag that lands in this very cycle.
                wp_d     = '0;
                rp_d     = '0;
                pend_w_d = key0_flag;
                pend_r_d = key1_flag;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            beat_q     <= '0;
            pend_w_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            pend_c_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            beat_q     <= beat_d;
            pend_w_q   <= pend_w_d;
            pend_r_q   <= pend_r_d;
            pend_c_q   <= pend_c_d;
            rd_valid_q <= rden;
        end
    end

    // Address/data are gated so the ports read as zero outside a burst.
    assign wren     = (state_q == ST_WRITE);
    assign rden     = (state_q == ST_READ);
    assign busy     = (state_q != ST_IDLE);
    assign wr_addr  = wren ? wp_q : '0;
    assign wr_data  = wren ? pat_of(wp_q) : '0;
    assign rd_addr  = rden ? rp_q : '0;
    assign rd_valid = rd_valid_q;

`ifdef DPRAM_KEY_CTRL_CHECK_EN
    logic [ADDR_W-1:0] rd_addr_d1_q;
    logic [7:0]        err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rd_valid_q && (rd_data != pat_of(rd_addr_d1_q)) && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_d1_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            rd_addr_d1_q <= rd_addr;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

    logic unused_ok;
    assign unused_ok = key0_state;
`else
    assign err_cnt = 8'd0;

    logic unused_ok;
    assign unused_ok = key0_state ^ (^rd_data);
`endif

endmodule

// File: tb/tb_dpram_key_ctrl.sv
// Directed bench for dpram_key_ctrl with a 1-cycle-latency RAM read model.
module tb_dpram_key_ctrl;

`ifdef DPRAM_KEY_CTRL_CHECK_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key0_flag = 1'b0, key0_state = 1'b0;
    logic       key1_flag = 1'b0, key1_state = 1'b0;
    logic [7:0] rd_data;
    logic       wren, rden, rd_valid, busy;
    logic [7:0] wr_addr, wr_data, rd_addr, err_cnt;
    logic       corrupt = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dpram_key_ctrl #(.LONG_CNT(26'd100)) dut (
        .clk       (clk),
        .rst       (rst),
        .key0_flag (key0_flag),
        .key0_state(key0_state),
        .key1_flag (key1_flag),
        .key1_state(key1_state),
        .rd_data   (rd_data),
        .wren      (wren),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rden      (rden),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    // RAM port B model: ideal contents addr^A5, optional single-bit flip at addr 2.
    always_ff @(posedge clk) begin
        if (rden) rd_data <= (rd_addr ^ 8'hA5) ^ ((corrupt && rd_addr == 8'd2) ? 8'h01 : 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic k0, input logic k1);
        key0_flag = k0;
        key1_flag = k1;
        tick();
        key0_flag = 1'b0;
        key1_flag = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wren"}, wren, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_rden"}, rden, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk_quiet("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Called right after the flag edge; checks the 4 beats and the trailing IDLE cycle.
    task automatic exp_write(input logic [7:0] base);
        logic [7:0] a;
        for (int b = 0; b < 4; b++) begin
            tick();
            a = base + 8'(b);
            chk("wr_wren", wren, 1);
            chk("wr_addr", wr_addr, a);
            chk("wr_data", wr_data, a ^ 8'hA5);
            chk("wr_busy", busy, 1);
            chk("wr_rden", rden, 0);
        end
        tick();
        chk("wr_end_wren", wren, 0);
        chk("wr_end_rden", rden, 0);
        chk("wr_end_busy", busy, 0);
    endtask

    task automatic exp_read(input logic [7:0] base);
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("rd_rden", rden, 1);
            chk("rd_addr", rd_addr, base + 8'(b));
            chk("rd_valid", rd_valid, (b != 0) ? 1 : 0);
            chk("rd_wren", wren, 0);
        end
        tick();
        chk("rd_end_rden", rden, 0);
        chk("rd_end_valid", rd_valid, 1);
        chk("rd_end_busy", busy, 0);
    endtask

    initial begin
        int wc, rc, clr_cnt, clr_at, first_rd, beats;
        logic [7:0] e;

        // reset state
        #2;
        do_reset();
        chk_quiet("post_reset");

        // single write burst, then a second one continues at wp=4
        pulse(1'b1, 1'b0);
        chk("t2_latency_wren", wren, 0);
        exp_write(8'd0);
        pulse(1'b1, 1'b0);
        exp_write(8'd4);

        // same-cycle write and read: write first, one IDLE gap, then read
        do_reset();
        pulse(1'b1, 1'b1);
        exp_write(8'd0);
        exp_read(8'd0);
        tick();
        chk("t3_valid_drop", rd_valid, 0);
        chk("t3_err_cnt", err_cnt, 0);

        // three key1 flags during a write burst collapse to one read burst
        wc = 0; rc = 0; first_rd = -1;
        for (int i = 0; i < 25; i++) begin
            key0_flag = (i == 0);
            key1_flag = (i >= 2 && i <= 4);
            tick();
            if (wren) wc++;
            if (rden) begin
                rc++;
                if (first_rd < 0) first_rd = int'(rd_addr);
            end
        end
        key0_flag = 1'b0;
        key1_flag = 1'b0;
        chk("t4_write_beats", wc, 4);
        chk("t4_read_beats", rc, 4);
        chk("t4_first_rd_addr", first_rd, 4);

        // 64 write bursts: contiguous addresses wrapping 255 -> 0
        do_reset();
        e = 8'd0;
        beats = 0;
        for (int n = 0; n < 64; n++) begin
            pulse(1'b1, 1'b0);
            for (int c = 0; c < 5; c++) begin
                tick();
                if (wren) begin
                    chk("t5_wrap_addr", wr_addr, e);
                    e = e + 8'd1;
                    beats++;
                end
            end
        end
        chk("t5_total_beats", beats, 256);
        pulse(1'b1, 1'b0);
        tick();
        chk("t5_wrapped_start", wr_addr, 0);
        chk("t5_wrapped_wren", wren, 1);
        repeat (4) tick();

        // long press: read burst first, single CLEAR cycle 100 edges after press
        do_reset();
        pulse(1'b1, 1'b0);
        repeat (5) tick();
        key1_state = 1'b1;
        pulse(1'b0, 1'b1);
        rc = 0; clr_cnt = 0; clr_at = -1;
        for (int i = 1; i <= 160; i++) begin
            if (i == 150) key1_state = 1'b0;
            tick();
            if (rden) rc++;
            if (busy && !wren && !rden) begin
                clr_cnt++;
                if (clr_at < 0) clr_at = i;
            end
        end
        chk("t6_read_beats", rc, 4);
        chk("t6_clear_cycles", clr_cnt, 1);
        chk("t6_clear_at", clr_at, 100);
        pulse(1'b1, 1'b0);
        exp_write(8'd0);
        pulse(1'b0, 1'b1);
        exp_read(8'd0);

        // corrupted word at addr 2
        do_reset();
        corrupt = 1'b1;
        pulse(1'b0, 1'b1);
        exp_read(8'd0);
        tick();
        chk("t7_err_cnt", err_cnt, CHK_EN);
        corrupt = 1'b0;

        // reset in the middle of a read burst
        pulse(1'b0, 1'b1);
        tick();
        tick();
        chk("t8_pre_rden", rden, 1);
        chk("t8_pre_valid", rd_valid, 1);
        chk("t8_pre_rd_addr", rd_addr, 5);
        chk("t8_pre_err", err_cnt, CHK_EN);
        rst = 1'b0;
        #1;
        chk_quiet("t8_async");
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("t8_after_busy", busy, 0);
        pulse(1'b1, 1'b0);
        exp_write(8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
